id_ex_hazard: RTL and testbench
===============================

Name: id_ex_hazard

Overview:
- Combines the ID/EX control pipeline register with load-use hazard detection for the 5-stage RISC-V core.
- Consumes the decoded control bits from the control decoder plus the register indices of the instruction in ID, and registers them into the EX stage.
- Generates stall_o, which drives the control decoder's stall input, and drives the PC and IF/ID write enables.
- Honours a whole-pipeline freeze from the data cache and the IF/ID flush for a taken branch resolved in ID.

Parameters:
- LOAD_USE_BUBBLES, 1, number of bubble cycles inserted per load-use hazard; legal range 1..3.
- CNT_W, 2, width of the bubble counter; must satisfy 2^CNT_W > LOAD_USE_BUBBLES.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- Branch_i, MemtoReg_i, MemWrite_i, MemRead_i, ALUSrc_i, RegWrite_i  in  1 each  control bits from the decoder.
- ALUOp_i  in  2  ALU op class from the decoder.
- id_rs1_i, id_rs2_i, id_rd_i  in  5 each  register indices of the instruction in ID.
- branch_taken_i  in  1  branch in ID resolved taken.
- mem_stall_i  in  1  data cache busy; freeze the pipeline.
- ex_MemtoReg_o, ex_MemWrite_o, ex_MemRead_o, ex_ALUSrc_o, ex_RegWrite_o  out  1 each  registered EX control bits.
- ex_ALUOp_o  out  2  registered ALU op class.
- ex_rs1_o, ex_rs2_o, ex_rd_o  out  5 each  registered indices, fed to forwarding.
- stall_o  out  1  load-use stall; goes to the decoder's stall input.
- pc_write_o, ifid_write_o  out  1 each  write enables for the PC and the IF/ID register.
- ifid_flush_o  out  1  clear IF/ID on a taken branch.

Behaviour:
- Reset: on a rising clk_i edge with rst_i=1, all ex_* outputs clear to 0 and the bubble counter clears to 0.
  - Combinational outputs then evaluate to stall_o=0, pc_write_o=1, ifid_write_o=1, ifid_flush_o=0.
  - A reset issued during a stall or freeze aborts it; there is no residual stall.
- Hazard term: haz = ex_MemRead_o & (ex_rd_o != 0) & ((ex_rd_o == id_rs1_i) | (ex_rd_o == id_rs2_i)).
  - Comparison is against both rs fields regardless of instruction format.
  - x0 never triggers a hazard.
- Bubble counter cnt, 2-state behaviour:
  - IDLE: cnt=0.
  - BUBBLE: cnt!=0.
  - In IDLE, haz=1 and mem_stall_i=0 → at the next edge, load cnt = LOAD_USE_BUBBLES-1. With the default of 1, cnt stays 0 and only the single-cycle haz stall occurs.
  - In BUBBLE with mem_stall_i=0 → cnt decrements each edge.
- stall_o = (haz | cnt!=0) & ~mem_stall_i.
- ID/EX register update at each edge, in priority order:
  - rst_i: clear all ex_* to 0.
  - mem_stall_i=1: hold all ex_* and cnt.
  - stall_o=1: insert a bubble. All ex_* control bits = 0, including ex_MemRead_o, even though the decoder does not gate MemRead on its stall input. The indices are still captured.
  - Otherwise: capture the *_i inputs.
- Branch_i is consumed only for the ID-stage flush decision and is not registered.
- pc_write_o = ifid_write_o = ~(stall_o | mem_stall_i).
- ifid_flush_o = branch_taken_i & ~stall_o & ~mem_stall_i.
  - While in a load-use stall, a taken branch is ignored because its operands are not yet valid; it is re-evaluated once the stall releases.
- The flush does not bubble ID/EX; the branch instruction itself proceeds normally.
- Latency: all ex_* outputs have 1 cycle of latency from the *_i inputs. stall_o, pc_write_o, ifid_write_o and ifid_flush_o are combinational, with 0 cycles of latency.
- Simultaneous haz and mem_stall_i: the freeze wins. The hazard is re-detected after the freeze, because ex_* are held.

Test Plan:
- Reset: hold rst_i=1 for 2 cycles with random inputs → all ex_*=0, stall_o=0, pc_write_o=1, ifid_flush_o=0.
- Load-use: cycle0 MemRead_i=1, RegWrite_i=1, MemtoReg_i=1, id_rd_i=5; cycle1 id_rs1_i=5.
  - Cycle1: stall_o=1, pc_write_o=0.
  - Cycle2: ex_MemRead_o=0, ex_RegWrite_o=0 (bubble), stall_o=0.
- x0 and no-match cases:
  - Load to rd=0 followed by a consumer with rs1=0 → stall_o stays 0.
  - Load to rd=7 followed by rs1=3, rs2=4 → stall_o=0.
- Freeze: assert mem_stall_i=1 for 3 cycles with ex_ALUOp_o=2'b10 → ex_* held for all 3 cycles, pc_write_o=0, stall_o=0. An overlapping load-use hazard raises stall_o on the first free cycle.
- Branch: branch_taken_i=1 with no hazard → ifid_flush_o=1 and the ID/EX capture is normal. The same during a load-use stall → ifid_flush_o=0 until stall_o drops.
- LOAD_USE_BUBBLES=3: a single load-use event → stall_o=1 for exactly 3 consecutive cycles, and 3 bubbles appear in ex_*. Asserting rst_i on the 2nd stall cycle → stall_o=0 on the next cycle.

Source files
------------

// File: rtl/id_ex_hazard.sv
// ID/EX control pipeline register with load-use hazard detection.
// Drives the stall, PC/IF-ID write enables and the IF/ID flush.
module id_ex_hazard #(
   parameter int LOAD_USE_BUBBLES = 1,
   parameter int CNT_W            = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       Branch_i,
   input  logic       MemtoReg_i,
   input  logic       MemWrite_i,
   input  logic       MemRead_i,
   input  logic       ALUSrc_i,
   input  logic       RegWrite_i,
   input  logic [1:0] ALUOp_i,
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   input  logic [4:0] id_rd_i,
   input  logic       branch_taken_i,
   input  logic       mem_stall_i,
   output logic       ex_MemtoReg_o,
   output logic       ex_MemWrite_o,
   output logic       ex_MemRead_o,
   output logic       ex_ALUSrc_o,
   output logic       ex_RegWrite_o,
   output logic [1:0] ex_ALUOp_o,
   output logic [4:0] ex_rs1_o,
   output logic [4:0] ex_rs2_o,
   output logic [4:0] ex_rd_o,
   output logic       stall_o,
   output logic       pc_write_o,
   output logic       ifid_write_o,
   output logic       ifid_flush_o
);

   logic             memtoreg_q, memtoreg_d;
   logic             memwrite_q, memwrite_d;
   logic             memread_q,  memread_d;
   logic             alusrc_q,   alusrc_d;
   logic             regwrite_q, regwrite_d;
   logic [1:0]       aluop_q,    aluop_d;
   logic [4:0]       rs1_q,      rs1_d;
   logic [4:0]       rs2_q,      rs2_d;
   logic [4:0]       rd_q,       rd_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic             haz;
   logic             stall;

   // Branch_i only matters through branch_taken_i; it is not carried to EX.
   logic unused_branch;
   assign unused_branch = Branch_i;

   // Load-use detection against the load sitting in EX; x0 never hazards.
   always_comb begin
      haz   = memread_q & (rd_q != 5'd0) &
              ((rd_q == id_rs1_i) | (rd_q == id_rs2_i));
      stall = (haz | (cnt_q != '0)) & ~mem_stall_i;
   end

   // Next state: freeze holds everything, stall bubbles the controls.
   always_comb begin
      memtoreg_d = memtoreg_q;
      memwrite_d = memwrite_q;
      memread_d  = memread_q;
      alusrc_d   = alusrc_q;
      regwrite_d = regwrite_q;
      aluop_d    = aluop_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      rd_d       = rd_q;
      cnt_d      = cnt_q;
      unique case (1'b1)
         mem_stall_i: ;
         stall: begin
            memtoreg_d = 1'b0;
            memwrite_d = 1'b0;
            memread_d  = 1'b0;
            alusrc_d   = 1'b0;
            regwrite_d = 1'b0;
            aluop_d    = 2'b00;
            rs1_d      = id_rs1_i;
            rs2_d      = id_rs2_i;
            rd_d       = id_rd_i;
            if (cnt_q != '0)
               cnt_d = cnt_q - CNT_W'(1);
            else
               cnt_d = CNT_W'(LOAD_USE_BUBBLES - 1);
         end
         default: begin
            memtoreg_d = MemtoReg_i;
            memwrite_d = MemWrite_i;
            memread_d  = MemRead_i;
            alusrc_d   = ALUSrc_i;
            regwrite_d = RegWrite_i;
            aluop_d    = ALUOp_i;
            rs1_d      = id_rs1_i;
            rs2_d      = id_rs2_i;
            rd_d       = id_rd_i;
         end
      endcase
   end

   // ID/EX register and bubble counter with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         memtoreg_q <= 1'b0;
         memwrite_q <= 1'b0;
         memread_q  <= 1'b0;
         alusrc_q   <= 1'b0;
         regwrite_q <= 1'b0;
         aluop_q    <= 2'b00;
         rs1_q      <= 5'd0;
         rs2_q      <= 5'd0;
         rd_q       <= 5'd0;
         cnt_q      <= '0;
      end else begin
         memtoreg_q <= memtoreg_d;
         memwrite_q <= memwrite_d;
         memread_q  <= memread_d;
         alusrc_q   <= alusrc_d;
         regwrite_q <= regwrite_d;
         aluop_q    <= aluop_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
      end
   end

   assign ex_MemtoReg_o = memtoreg_q;
   assign ex_MemWrite_o = memwrite_q;
   assign ex_MemRead_o  = memread_q;
   assign ex_ALUSrc_o   = alusrc_q;
   assign ex_RegWrite_o = regwrite_q;
   assign ex_ALUOp_o    = aluop_q;
   assign ex_rs1_o      = rs1_q;
   assign ex_rs2_o      = rs2_q;
   assign ex_rd_o       = rd_q;
   assign stall_o       = stall;
   assign pc_write_o    = ~(stall | mem_stall_i);
   assign ifid_write_o  = ~(stall | mem_stall_i);
   assign ifid_flush_o  = branch_taken_i & ~stall & ~mem_stall_i;

endmodule

// File: tb/tb_id_ex_hazard.sv
// Scoreboard bench for id_ex_hazard.
// Two instances: default single bubble (A) and three bubbles (B).
module tb_id_ex_hazard;

   localparam logic [6:0] LD  = 7'b1011100;
   localparam logic [6:0] RT  = 7'b0000110;
   localparam logic [6:0] NOP = 7'b0000000;
   localparam logic [1:0] CA  = 2'b01;
   localparam logic [1:0] CB  = 2'b10;
   localparam logic [1:0] CN  = 2'b00;

   logic       clk;
   logic       rst;
   logic       bt;
   logic       ms;
   logic [6:0] ctl;
   logic [4:0] rs1, rs2, rd;

   logic       a_m2r, a_mw, a_mr, a_alus, a_rw;
   logic [1:0] a_aluop;
   logic [4:0] a_rs1, a_rs2, a_rd;
   logic       a_stall, a_pcw, a_ifw, a_flush;
   logic       b_m2r, b_mw, b_mr, b_alus, b_rw;
   logic [1:0] b_aluop;
   logic [4:0] b_rs1, b_rs2, b_rd;
   logic       b_stall, b_pcw, b_ifw, b_flush;

   typedef struct {
      string      nm;
      logic [1:0] chk;
      logic [6:0] ctl;
      logic [14:0] idx;
      logic [3:0] comb;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   id_ex_hazard #(.LOAD_USE_BUBBLES(1), .CNT_W(2)) u_a (
      .clk_i(clk), .rst_i(rst), .Branch_i(bt),
      .MemtoReg_i(ctl[6]), .MemWrite_i(ctl[5]), .MemRead_i(ctl[4]),
      .ALUSrc_i(ctl[3]), .RegWrite_i(ctl[2]), .ALUOp_i(ctl[1:0]),
      .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rd_i(rd),
      .branch_taken_i(bt), .mem_stall_i(ms),
      .ex_MemtoReg_o(a_m2r), .ex_MemWrite_o(a_mw), .ex_MemRead_o(a_mr),
      .ex_ALUSrc_o(a_alus), .ex_RegWrite_o(a_rw), .ex_ALUOp_o(a_aluop),
      .ex_rs1_o(a_rs1), .ex_rs2_o(a_rs2), .ex_rd_o(a_rd),
      .stall_o(a_stall), .pc_write_o(a_pcw), .ifid_write_o(a_ifw),
      .ifid_flush_o(a_flush)
   );

   id_ex_hazard #(.LOAD_USE_BUBBLES(3), .CNT_W(2)) u_b (
      .clk_i(clk), .rst_i(rst), .Branch_i(bt),
      .MemtoReg_i(ctl[6]), .MemWrite_i(ctl[5]), .MemRead_i(ctl[4]),
      .ALUSrc_i(ctl[3]), .RegWrite_i(ctl[2]), .ALUOp_i(ctl[1:0]),
      .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rd_i(rd),
      .branch_taken_i(bt), .mem_stall_i(ms),
      .ex_MemtoReg_o(b_m2r), .ex_MemWrite_o(b_mw), .ex_MemRead_o(b_mr),
      .ex_ALUSrc_o(b_alus), .ex_RegWrite_o(b_rw), .ex_ALUOp_o(b_aluop),
      .ex_rs1_o(b_rs1), .ex_rs2_o(b_rs2), .ex_rd_o(b_rd),
      .stall_o(b_stall), .pc_write_o(b_pcw), .ifid_write_o(b_ifw),
      .ifid_flush_o(b_flush)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic cmp(input string nm, input string what,
                      input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s.%s got %h want %h", nm, what, act, exp);
      end
   endtask

   // Monitor: pops one expectation per cycle and checks the selected DUT.
   logic [6:0]  m_ctl;
   logic [14:0] m_idx;
   logic [3:0]  m_comb;
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         if (e.chk != 2'b00) begin
            if (e.chk[0]) begin
               m_ctl  = {a_m2r, a_mw, a_mr, a_alus, a_rw, a_aluop};
               m_idx  = {a_rs1, a_rs2, a_rd};
               m_comb = {a_stall, a_pcw, a_ifw, a_flush};
            end else begin
               m_ctl  = {b_m2r, b_mw, b_mr, b_alus, b_rw, b_aluop};
               m_idx  = {b_rs1, b_rs2, b_rd};
               m_comb = {b_stall, b_pcw, b_ifw, b_flush};
            end
            cmp(e.nm, "ctl", 32'(m_ctl), 32'(e.ctl));
            cmp(e.nm, "idx", 32'(m_idx), 32'(e.idx));
            cmp(e.nm, "stall_pcw_ifw_flush", 32'(m_comb), 32'(e.comb));
         end
      end
   end

   task automatic step(input string nm, input logic [1:0] chk,
                       input logic r, input logic [6:0] c,
                       input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input logic b, input logic m,
                       input logic [6:0] ec, input logic [4:0] e1,
                       input logic [4:0] e2, input logic [4:0] ed,
                       input logic es, input logic ep, input logic ef);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; ctl = c; rs1 = s1; rs2 = s2; rd = d; bt = b; ms = m;
      e.nm   = nm;
      e.chk  = chk;
      e.ctl  = ec;
      e.idx  = {e1, e2, ed};
      e.comb = {es, ep, ep, ef};
      sb.push_back(e);
   endtask

   initial begin
      rst = 1'b1; bt = 1'b0; ms = 1'b0;
      ctl = 7'($urandom); rs1 = 5'($urandom);
      rs2 = 5'($urandom); rd = 5'($urandom);

      // reset with random operands
      step("RST1", CA, 1, 7'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), 0, 0, NOP, 0, 0, 0, 0, 1, 0);
      step("RST2", CA, 1, 7'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), 0, 0, NOP, 0, 0, 0, 0, 1, 0);
      // load-use
      step("LU0", CA, 0, LD, 1, 2, 5, 0, 0, NOP, 0, 0, 0, 0, 1, 0);
      step("LU1", CA, 0, RT, 5, 6, 8, 0, 0, LD, 1, 2, 5, 1, 0, 0);
      step("LU2", CA, 0, RT, 5, 6, 8, 0, 0, NOP, 5, 6, 8, 0, 1, 0);
      // x0 and no-match
      step("X0A", CA, 0, LD, 1, 2, 0, 0, 0, RT, 5, 6, 8, 0, 1, 0);
      step("X0B", CA, 0, RT, 0, 0, 9, 0, 0, LD, 1, 2, 0, 0, 1, 0);
      step("NM0", CA, 0, LD, 1, 2, 7, 0, 0, RT, 0, 0, 9, 0, 1, 0);
      step("NM1", CA, 0, RT, 3, 4, 10, 0, 0, LD, 1, 2, 7, 0, 1, 0);
      // freeze holding an ALUOp=10 instruction
      step("FZ0", CA, 0, RT, 11, 12, 13, 0, 0, RT, 3, 4, 10, 0, 1, 0);
      step("FZ1", CA, 0, LD, 1, 2, 20, 0, 1, RT, 11, 12, 13, 0, 0, 0);
      step("FZ2", CA, 0, LD, 1, 2, 20, 0, 1, RT, 11, 12, 13, 0, 0, 0);
      step("FZ3", CA, 0, LD, 1, 2, 20, 1, 1, RT, 11, 12, 13, 0, 0, 0);
      step("FZ4", CA, 0, LD, 1, 2, 20, 0, 0, RT, 11, 12, 13, 0, 1, 0);
      // freeze overlapping a load-use hazard
      step("FH1", CA, 0, RT, 4, 20, 21, 0, 1, LD, 1, 2, 20, 0, 0, 0);
      step("FH2", CA, 0, RT, 4, 20, 21, 0, 0, LD, 1, 2, 20, 1, 0, 0);
      step("FH3", CA, 0, RT, 4, 20, 21, 0, 0, NOP, 4, 20, 21, 0, 1, 0);
      // taken branch, then taken branch during a stall
      step("BR0", CA, 0, RT, 1, 2, 22, 1, 0, RT, 4, 20, 21, 0, 1, 1);
      step("BR1", CA, 0, LD, 1, 2, 23, 0, 0, RT, 1, 2, 22, 0, 1, 0);
      step("BR2", CA, 0, RT, 23, 0, 24, 1, 0, LD, 1, 2, 23, 1, 0, 0);
      step("BR3", CA, 0, RT, 23, 0, 24, 1, 0, NOP, 23, 0, 24, 0, 1, 1);
      step("BR4", CA, 0, NOP, 0, 0, 0, 0, 0, RT, 23, 0, 24, 0, 1, 0);
      // three-bubble instance
      step("B_R", CN, 1, NOP, 0, 0, 0, 0, 0, NOP, 0, 0, 0, 0, 1, 0);
      step("B_LD", CB, 0, LD, 1, 2, 5, 0, 0, NOP, 0, 0, 0, 0, 1, 0);
      step("B_S1", CB, 0, RT, 5, 6, 8, 0, 0, LD, 1, 2, 5, 1, 0, 0);
      step("B_S2", CB, 0, RT, 5, 6, 8, 0, 0, NOP, 5, 6, 8, 1, 0, 0);
      step("B_S3", CB, 0, RT, 5, 6, 8, 0, 0, NOP, 5, 6, 8, 1, 0, 0);
      step("B_S4", CB, 0, RT, 5, 6, 8, 0, 0, NOP, 5, 6, 8, 0, 1, 0);
      step("B_E", CB, 0, NOP, 0, 0, 0, 0, 0, RT, 5, 6, 8, 0, 1, 0);
      // reset on the second stall cycle aborts the bubble train
      step("B_L2", CB, 0, LD, 1, 2, 5, 0, 0, NOP, 0, 0, 0, 0, 1, 0);
      step("B_T1", CB, 0, RT, 5, 6, 8, 0, 0, LD, 1, 2, 5, 1, 0, 0);
      step("B_T2", CB, 1, RT, 5, 6, 8, 0, 0, NOP, 5, 6, 8, 1, 0, 0);
      step("B_T3", CB, 0, RT, 5, 6, 8, 0, 0, NOP, 0, 0, 0, 0, 1, 0);
      step("B_T4", CB, 0, NOP, 0, 0, 0, 0, 0, RT, 5, 6, 8, 0, 1, 0);

      for (int i = 0; i < 8 && sb.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain got %0d pending want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
